// File: rtl/aes_spi_frame_if.sv
// SPI host pins and AES core handshake for aes_spi_frame.
// slave is the frame block's view; master is the host/core side.
interface aes_spi_frame_if #(
    parameter int unsigned K = 128
);
    logic         sck;
    logic         sdi;
    logic         load;
    logic         sdo;
    logic         done;
    logic         err;
    logic         core_start;
    logic [127:0] core_text;
    logic [K-1:0] core_key;
    logic         core_dir;
    logic         core_done;
    logic [127:0] core_result;

    modport slave (
        input  sck, sdi, load, core_done, core_result,
        output sdo, done, err, core_start, core_text, core_key, core_dir
    );

    modport master (
        output sck, sdi, load, core_done, core_result,
        input  sdo, done, err, core_start, core_text, core_key, core_dir
    );
endinterface

// File: rtl/aes_spi_frame.sv
// SPI-slave frame front end: shifts in NBLK blocks, a key and a mode byte, runs each block
// through an AES core over start/done, then shifts all results out on sdo.
module aes_spi_frame #(
    parameter int unsigned K    = 128,
    parameter int unsigned NBLK = 1
) (
    input logic            clk,
    input logic            reset,
    aes_spi_frame_if.slave bus
);
    localparam int unsigned FR  = NBLK * 128 + K + 8;
    localparam int unsigned OW  = NBLK * 128;
    localparam int unsigned CW  = $clog2(FR + 2);
    localparam int unsigned OCW = $clog2(OW + 1);
    localparam int unsigned BW  = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [2:0] {StIdle, StShiftIn, StRun, StWaitCore, StShiftOut} state_e;

    state_e         state_q;
    logic [2:0]     sck_sync_q;
    logic [2:0]     load_sync_q;
    logic [1:0]     sdi_sync_q;
    logic [CW-1:0]  cnt_q;
    logic [OCW-1:0] ocnt_q;
    logic [BW-1:0]  blk_q;
    logic [FR-1:0]  frame_q;
    logic [OW-1:0]  res_q;
    logic           sdo_q;
    logic           done_q;
    logic           err_q;
    logic           start_q;

    logic           sck_rise, sck_fall, load_rise, load_fall;
    logic [OW-1:0]  blocks_rot;
    logic [OW-1:0]  res_next;

    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
    assign load_rise = load_sync_q[1] & ~load_sync_q[2];
    assign load_fall = ~load_sync_q[1] & load_sync_q[2];

    // Blocks rotate by one slot per completed core run so the current block is always on top;
    // results are appended in order, leaving slot 0 in the MSBs once the last one lands.
    if (NBLK > 1) begin : g_multi
        assign blocks_rot = {frame_q[FR-129 -: OW-128], frame_q[FR-1 -: 128]};
        assign res_next   = {res_q[OW-129:0], bus.core_result};
    end else begin : g_single
        assign blocks_rot = frame_q[FR-1 -: OW];
        assign res_next   = bus.core_result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            sck_sync_q  <= '0;
            load_sync_q <= '0;
            sdi_sync_q  <= '0;
            cnt_q       <= '0;
            ocnt_q      <= '0;
            blk_q       <= '0;
            sdo_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], bus.sck};
            load_sync_q <= {load_sync_q[1:0], bus.load};
            sdi_sync_q  <= {sdi_sync_q[0], bus.sdi};
            start_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_rise) begin
                        state_q <= StShiftIn;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StShiftIn: begin
                    if (load_fall) begin
                        if (cnt_q == CW'(FR)) begin
                            state_q <= StRun;
                            blk_q   <= '0;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            err_q   <= 1'b1;
                        end
                    end else if (sck_rise && load_sync_q[1]) begin
                        frame_q <= {frame_q[FR-2:0], sdi_sync_q[1]};
                        if (cnt_q != CW'(FR + 1)) cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    state_q <= StWaitCore;
                    if (load_rise) err_q <= 1'b1;
                end
                StWaitCore: begin
                    if (load_rise) err_q <= 1'b1;
                    if (bus.core_done) begin
                        res_q              <= res_next;
                        frame_q[FR-1 -: OW] <= blocks_rot;
                        if (blk_q == BW'(NBLK - 1)) begin
                            state_q <= StShiftOut;
                            done_q  <= 1'b1;
                            sdo_q   <= res_next[OW-1];
                            ocnt_q  <= '0;
                        end else begin
                            state_q <= StRun;
                            blk_q   <= blk_q + 1'b1;
                            start_q <= 1'b1;
                        end
                    end
                end
                StShiftOut: begin
                    if (load_rise) begin
                        state_q <= StShiftIn;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        sdo_q   <= 1'b0;
                    end else if (sck_fall) begin
                        if (ocnt_q == OCW'(OW - 1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b0;
                            sdo_q   <= 1'b0;
                        end else begin
                            ocnt_q <= ocnt_q + 1'b1;
                            res_q  <= {res_q[OW-2:0], res_q[OW-1]};
                            sdo_q  <= res_q[OW-2];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sdo        = sdo_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.core_start = start_q;
    assign bus.core_text  = frame_q[FR-1 -: 128];
    assign bus.core_key   = frame_q[8 +: K];
    assign bus.core_dir   = frame_q[0];
endmodule

// File: tb/tb_aes_spi_frame.sv
// Bench for aes_spi_frame: three instances (K128/N1, K256/N1, K128/N2) share sck/sdi,
// each with its own load strobe and behavioural AES core.
module tb_aes_spi_frame;
    typedef struct {
        int           g;
        logic [127:0] t0;
        logic [127:0] t1;
        logic [255:0] key;
        logic [7:0]   mode;
        logic [255:0] res;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, sck, sdi;
    logic [2:0]        load_v;
    logic [2:0]        cdone_v = '0;
    logic [2:0][127:0] cres_v  = '0;
    logic [2:0]        sdo_v, done_v, err_v, start_v, dir_v;
    logic [2:0][127:0] text_v;
    logic [2:0][255:0] key_v;

    int checks = 0;
    int errors = 0;
    int lat    = 12;

    int           start_cnt [3] = '{0, 0, 0};
    int           unstable  [3] = '{0, 0, 0};
    bit           pend      [3] = '{0, 0, 0};
    int           tmr       [3] = '{0, 0, 0};
    logic [127:0] cap_text  [3];
    logic [255:0] cap_key   [3];
    logic         cap_dir   [3];
    logic [127:0] exp_txt   [3][8];
    int           exp_n     [3] = '{0, 0, 0};
    int           exp_h     [3] = '{0, 0, 0};
    logic [255:0] exp_key   [3];
    logic         exp_dir   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned KG = (g == 1) ? 256 : 128;
        localparam int unsigned NG = (g == 2) ? 2 : 1;
        aes_spi_frame_if #(.K(KG)) bus ();
        assign bus.sck         = sck;
        assign bus.sdi         = sdi;
        assign bus.load        = load_v[g];
        assign bus.core_done   = cdone_v[g];
        assign bus.core_result = cres_v[g];
        assign sdo_v[g]        = bus.sdo;
        assign done_v[g]       = bus.done;
        assign err_v[g]        = bus.err;
        assign start_v[g]      = bus.core_start;
        assign dir_v[g]        = bus.core_dir;
        assign text_v[g]       = bus.core_text;
        assign key_v[g]        = 256'(bus.core_key);
        aes_spi_frame #(.K(KG), .NBLK(NG)) u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
    end

    function automatic int kk(input int g);
        return (g == 1) ? 256 : 128;
    endfunction
    function automatic int nb(input int g);
        return (g == 2) ? 2 : 1;
    endfunction
    function automatic int fr(input int g);
        return nb(g) * 128 + kk(g) + 8;
    endfunction

    // Stand-in AES: known FIPS-197 vectors, otherwise a keyed byte rotation.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [255:0] k,
                                             input logic d);
        if (!d && t == 128'h3243f6a8885a308d313198a2e0370734 &&
            k == 256'h2b7e151628aed2a6abf7158809cf4f3c)
            return 128'h3925841d02dc09fbdc118597196a0b32;
        if (d && t == 128'h8ea2b7ca516745bfeafc49904b496089 &&
            k == 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f)
            return 128'h00112233445566778899aabbccddeeff;
        if (!d && t == 128'h00112233445566778899aabbccddeeff &&
            k == 256'h000102030405060708090a0b0c0d0e0f)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        return {t[119:0], t[127:120]} ^ k[127:0] ^ k[255:128] ^ {128{d}};
    endfunction

    function automatic logic [255:0] ref_out(input vec_t v);
        logic [127:0] r0;
        r0 = core_fn(v.t0, v.key, v.mode[0]);
        if (nb(v.g) == 2) return {r0, core_fn(v.t1, v.key, v.mode[0])};
        return {128'b0, r0};
    endfunction

    function automatic logic [511:0] mk_frame(input vec_t v);
        logic [511:0] f;
        f = 512'(v.t0);
        if (nb(v.g) == 2) f = (f << 128) | 512'(v.t1);
        f = (f << kk(v.g)) | 512'(v.key);
        f = (f << 8) | 512'(v.mode);
        return f;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Behavioural core: latches the request on core_start, answers after lat cycles.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            cdone_v[g] <= 1'b0;
            if (pend[g]) begin
                if (text_v[g] !== cap_text[g] || key_v[g] !== cap_key[g] ||
                    dir_v[g] !== cap_dir[g])
                    unstable[g] <= unstable[g] + 1;
                if (tmr[g] == 0) begin
                    cdone_v[g] <= 1'b1;
                    cres_v[g]  <= core_fn(cap_text[g], cap_key[g], cap_dir[g]);
                    pend[g]    <= 1'b0;
                end else begin
                    tmr[g] <= tmr[g] - 1;
                end
            end
            if (start_v[g] === 1'b1) begin
                start_cnt[g] <= start_cnt[g] + 1;
                pend[g]      <= 1'b1;
                tmr[g]       <= lat - 1;
                cap_text[g]  <= text_v[g];
                cap_key[g]   <= key_v[g];
                cap_dir[g]   <= dir_v[g];
                chk1("start_expected", exp_h[g] < exp_n[g], 1'b1);
                if (exp_h[g] < exp_n[g]) begin
                    chk("core_text", 256'(text_v[g]), 256'(exp_txt[g][exp_h[g] % 8]));
                    chk("core_key", key_v[g], exp_key[g]);
                    chk1("core_dir", dir_v[g], exp_dir[g]);
                    exp_h[g] <= exp_h[g] + 1;
                end
            end
        end
    end

    task automatic push(input int g, input logic [127:0] t);
        exp_txt[g][exp_n[g] % 8] = t;
        exp_n[g]++;
    endtask

    task automatic expect_frame(input vec_t v);
        push(v.g, v.t0);
        if (nb(v.g) == 2) push(v.g, v.t1);
        exp_key[v.g] = v.key;
        exp_dir[v.g] = v.mode[0];
    endtask

    task automatic send_frame(input int g, input logic [511:0] fb, input int n, input bit hold);
        if (!hold) begin
            load_v[g] = 1'b1;
            repeat (6) @(negedge clk);
        end
        for (int i = n - 1; i >= 0; i--) begin
            sdi = fb[i];
            repeat (2) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        load_v[g] = 1'b0;
    endtask

    task automatic read_bits(input int g, input int n, output logic [255:0] rd);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            rd  = {rd[254:0], sdo_v[g]};
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (done_v[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1("done_rise", done_v[g], 1'b1);
    endtask

    task automatic do_frame(input vec_t v, input bit hold);
        int           g;
        int           s0;
        logic [255:0] rd;
        g  = v.g;
        s0 = start_cnt[g];
        expect_frame(v);
        send_frame(g, mk_frame(v), fr(g), hold);
        wait_done(g);
        chk("start_count", 256'(start_cnt[g] - s0), 256'(nb(g)));
        chk1("err_clear", err_v[g], 1'b0);
        chk("texts_used", 256'(exp_n[g] - exp_h[g]), 256'(0));
        read_bits(g, nb(g) * 128, rd);
        chk("sdo_data", rd, v.res);
        repeat (2) @(negedge clk);
        chk1("done_fall", done_v[g], 1'b0);
        chk1("sdo_idle", sdo_v[g], 1'b0);
        chk("core_stable", 256'(unstable[g]), 256'(0));
    endtask

    task automatic bad_frame(input int g, input int n);
        logic [511:0] fb;
        int           s0;
        for (int i = 0; i < 16; i++) fb[i*32 +: 32] = $urandom;
        s0 = start_cnt[g];
        send_frame(g, fb, n, 1'b0);
        repeat (8) @(negedge clk);
        chk1("bad_err", err_v[g], 1'b1);
        chk1("bad_done", done_v[g], 1'b0);
        chk("bad_nostart", 256'(start_cnt[g] - s0), 256'(0));
    endtask

    function automatic vec_t rand_vec(input int g);
        vec_t v;
        v.g    = g;
        v.t0   = rand128();
        v.t1   = (nb(g) == 2) ? rand128() : 128'b0;
        v.key  = {rand128(), rand128()};
        if (kk(g) == 128) v.key[255:128] = '0;
        v.mode = 8'($urandom);
        v.res  = ref_out(v);
        return v;
    endfunction

    initial begin
        vec_t         tbl [3];
        vec_t         v;
        logic [255:0] rd;
        int           s0;
        int           n;

        reset  = 1'b0;
        sck    = 1'b0;
        sdi    = 1'b0;
        load_v = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk1("rst_done", done_v[g], 1'b0);
            chk1("rst_err", err_v[g], 1'b0);
            chk1("rst_sdo", sdo_v[g], 1'b0);
            chk1("rst_start", start_v[g], 1'b0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        tbl[0] = '{g: 0, t0: 128'h3243f6a8885a308d313198a2e0370734, t1: 128'h0,
                   key: 256'h2b7e151628aed2a6abf7158809cf4f3c, mode: 8'h00,
                   res: 256'h3925841d02dc09fbdc118597196a0b32};
        tbl[1] = '{g: 1, t0: 128'h8ea2b7ca516745bfeafc49904b496089, t1: 128'h0,
                   key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   mode: 8'h01, res: 256'h00112233445566778899aabbccddeeff};
        tbl[2] = '{g: 2, t0: 128'h00112233445566778899aabbccddeeff,
                   t1: 128'h3243f6a8885a308d313198a2e0370734,
                   key: 256'h000102030405060708090a0b0c0d0e0f, mode: 8'h00,
                   res: {128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                         core_fn(128'h3243f6a8885a308d313198a2e0370734,
                                 256'h000102030405060708090a0b0c0d0e0f, 1'b0)}};
        for (int i = 0; i < 3; i++) do_frame(tbl[i], 1'b0);

        // Short and overlong frames, then recovery with a good frame.
        bad_frame(0, 100);
        bad_frame(0, fr(0) + 3);
        do_frame(tbl[0], 1'b0);

        // Reset while waiting on the core; its late answer must be ignored.
        lat = 8;
        s0  = start_cnt[2];
        expect_frame(tbl[2]);
        send_frame(2, mk_frame(tbl[2]), fr(2), 1'b0);
        n = 0;
        while (start_cnt[2] == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_start", 256'(start_cnt[2] - s0), 256'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk1("midrst_done", done_v[2], 1'b0);
        chk1("midrst_err", err_v[2], 1'b0);
        chk1("midrst_sdo", sdo_v[2], 1'b0);
        chk1("midrst_start", start_v[2], 1'b0);
        exp_n[2] = exp_h[2];
        repeat (20) @(negedge clk);
        chk("midrst_nostart", 256'(start_cnt[2] - s0), 256'(1));
        chk1("midrst_late_done", done_v[2], 1'b0);
        lat = 12;
        do_frame(tbl[2], 1'b0);

        // Abort shift-out with a new load rise after 50 bits.
        v = tbl[0];
        expect_frame(v);
        send_frame(0, mk_frame(v), fr(0), 1'b0);
        wait_done(0);
        read_bits(0, 50, rd);
        chk("partial_sdo", rd, v.res >> 78);
        load_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk1("abort_done", done_v[0], 1'b0);
        lat = $urandom_range(1, 20);
        do_frame(rand_vec(0), 1'b1);

        for (int i = 0; i < 3; i++) begin
            lat = $urandom_range(1, 20);
            do_frame(rand_vec($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_spi_frame.md
Name: aes_spi_frame

Overview:
- Synchronous SPI-slave front end for the AES cores; successor to the single-block serial wrapper.
- Receives a frame of NBLK plaintext/ciphertext blocks, a K-bit key and a mode byte over sck/sdi/load.
- Feeds the blocks one at a time to an AES core over a start/done handshake, buffers the results, and shifts NBLK*128 result bits out on sdo.
- All SPI inputs are oversampled in the clk domain; no logic is clocked by sck.

Parameters:
K, 128, key width in bits; legal values 128, 192, 256.
NBLK, 1, blocks per frame; legal range 1..8.
FR, NBLK*128+K+8, frame length in bits (derived; do not override).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset; reset=0 at a clk rising edge resets the block
sck  input  1  SPI clock from host; asynchronous to clk
sdi  input  1  SPI serial data in
load  input  1  host frame strobe; high while the frame is shifted in
sdo  output  1  SPI serial data out
done  output  1  result ready; high throughout result shift-out
err  output  1  frame error flag; sticky until the next accepted load rise
core_start  output  1  one-cycle start pulse to the AES core
core_text  output  128  current block to the core
core_key  output  K  key to the core
core_dir  output  1  0 = encrypt, 1 = decrypt
core_done  input  1  one-cycle pulse from the core; result is valid in that cycle
core_result  input  128  core output block

Behaviour:
- Synchronisers: sck, sdi and load each pass through 2 flops, then a third flop for edge detection. Event latency is 3 clk. The host must hold sck high and low for at least 4 clk each.
- Frame order, MSB first: block0..block(NBLK-1) (128 bits each), then the key (K bits), then the mode byte.
  - Mode bit0 sets core_dir; bits 7:1 are ignored.
- Reset (reset=0): state IDLE; sdo=0, done=0, err=0, core_start=0; bit counter, block index and synchroniser flops = 0. Frame and result registers are not reset.
- States:
  - IDLE: on synced load rise, go to SHIFT_IN, clear the bit counter and set err=0. core_done is ignored in IDLE.
  - SHIFT_IN: on each synced sck rise while load is high, shift synced sdi into the frame register LSB and increment the counter. The counter saturates at FR+1.
    - On synced load fall with count==FR: go to RUN with blk=0.
    - On synced load fall with any other count (short or overlong frame): set err=1, go to IDLE, issue no core_start.
  - RUN: exactly one cycle. core_start=1, core_text=block[blk]. Next state is WAIT_CORE.
    - core_text, core_key and core_dir stay stable from core_start until the matching core_done.
  - WAIT_CORE: on core_done, write core_result into result slot blk.
    - If blk==NBLK-1: go to SHIFT_OUT, set done=1 and drive sdo = MSB of slot 0 in the same edge.
    - Otherwise: increment blk and go to RUN.
  - SHIFT_OUT: on each synced sck fall, advance sdo to the next result bit. The host samples sdo on sck rise.
    - After NBLK*128 falls: done=0, sdo=0, go to IDLE.
- Simultaneous and abnormal events:
  - Load rise in SHIFT_OUT aborts output: done=0, go to SHIFT_IN as if from IDLE.
  - Load rise in RUN or WAIT_CORE is ignored; err=1, processing continues.
  - sck edges outside SHIFT_IN and SHIFT_OUT are ignored.
  - A core_done outside WAIT_CORE is ignored.
- Reset mid-operation: returns to IDLE on that edge. A late core_done arriving afterwards has no effect.
- Latency:
  - core_start is high 1 clk after the cycle in which the load fall is detected.
  - done rises on the clk edge that samples the last core_done.
- Counter widths: ceil(log2(FR+2)) bits for the frame counter; ceil(log2(NBLK*128+1)) bits for the output counter.

Test Plan:
- K=128, NBLK=1, frame {3243F6A8885A308D313198A2E0370734, 2B7E151628AED2A6ABF7158809CF4F3C, 00}; core model returns 3925841D02DC09FBDC118597196A0B32 after 12 clk -> one core_start with those text/key values and dir=0; done=1; 128 bits read on sdo equal 3925841D...0B32; done=0 afterwards.
- K=256, NBLK=1, text 8ea2b7ca516745bfeafc49904b496089, key 000102...1e1f, mode 01 -> core_dir=1; sdo yields the model's result 00112233445566778899aabbccddeeff.
- K=128, NBLK=2, blocks 00112233445566778899AABBCCDDEEFF then 3243F6A8885A308D313198A2E0370734 -> two core_start pulses in that order; output = result0 followed by result1 (256 bits).
- Short frame: load falls after 100 bits; separately, overlong frame of FR+3 bits -> err=1, no core_start, done stays 0; the next valid frame clears err and completes normally.
- reset=0 for 1 clk during WAIT_CORE -> next cycle all outputs are at reset values; core_done injected 5 clk later is ignored; a new full frame then produces the correct output.
- Load rises after 50 output bits in SHIFT_OUT -> done=0 within 4 clk; a fresh frame is accepted and its result shifted out correctly.
